// File: rtl/hnoc_leaf_router.sv
// hnoc_leaf_router
//   Leaf router for the hierarchical NoC. It joins NUM_PE local PE ports and
//   one uplink port. Every input has a FIFO. Every output has a round-robin
//   arbiter and a single registered output stage.
//   Internal port index p: 0..NUM_PE-1 are the PEs, NUM_PE is the uplink.
//
// Ports
//   i_clk, i_reset                     clock, async active-high reset
//   i_pe_data/_valid, o_pe_data_ready  PE ingress (port k at [k*DataWidth +: DataWidth])
//   o_pe_data/_valid, i_pe_data_ready  PE egress, same packing
//   i_up_data/_valid, o_up_data_ready  uplink ingress
//   o_up_data/_valid, i_up_data_ready  uplink egress
//   o_drop_count                       saturating count of misrouted uplink flits
module hnoc_leaf_router #(
    parameter int DataWidth = 36,
    parameter int AddrWidth = 4,
    parameter int NUM_PE    = 4,
    parameter int LocalBase = 0,
    parameter int FifoDepth = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [NUM_PE*DataWidth-1:0] i_pe_data,
    input  logic [NUM_PE-1:0]           i_pe_data_valid,
    output logic [NUM_PE-1:0]           o_pe_data_ready,
    output logic [NUM_PE*DataWidth-1:0] o_pe_data,
    output logic [NUM_PE-1:0]           o_pe_data_valid,
    input  logic [NUM_PE-1:0]           i_pe_data_ready,
    input  logic [DataWidth-1:0]        i_up_data,
    input  logic                        i_up_data_valid,
    output logic                        o_up_data_ready,
    output logic [DataWidth-1:0]        o_up_data,
    output logic                        o_up_data_valid,
    input  logic                        i_up_data_ready,
    output logic [7:0]                  o_drop_count
);
    localparam int NP  = NUM_PE + 1;
    localparam int PW  = $clog2(NP);
    localparam int FAW = $clog2(FifoDepth);
    localparam int CW  = FAW + 1;

    // The uplink takes the top slot of every port vector.
    logic [NP-1:0][DataWidth-1:0] in_data, head, out_data_q;
    logic [NP-1:0]                in_valid, in_ready, out_ready, out_valid_q;

    assign in_data   = {i_up_data, i_pe_data};
    assign in_valid  = {i_up_data_valid, i_pe_data_valid};
    assign out_ready = {i_up_data_ready, i_pe_data_ready};
    assign {o_up_data_ready, o_pe_data_ready} = in_ready;
    assign {o_up_data, o_pe_data}             = out_data_q;
    assign {o_up_data_valid, o_pe_data_valid} = out_valid_q;

    // ---------------------------------------------------------------- FIFOs
    logic [DataWidth-1:0]   mem_q [NP][FifoDepth];
    logic [NP-1:0][FAW-1:0] wr_ptr_q, rd_ptr_q;
    logic [NP-1:0][CW-1:0]  cnt_q;
    logic [NP-1:0]          push, pop, not_empty;
    logic [7:0]             drop_cnt_q;

    assign o_drop_count = drop_cnt_q;

    // Ready comes from FIFO occupancy only. It is forced low while reset is held.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            not_empty[i] = (cnt_q[i] != '0);
            in_ready[i]  = (cnt_q[i] != CW'(FifoDepth)) && !i_reset;
            push[i]      = in_valid[i] && in_ready[i];
            head[i]      = mem_q[i][rd_ptr_q[i]];
        end
    end

    // --------------------------------------------------------- route decode
    logic [NP-1:0][PW-1:0] dest;
    logic [NP-1:0]         routed, drop;

    always_comb begin
        int  d;
        logic is_local;
        d        = 0;
        is_local = 1'b0;
        dest     = '0;
        routed   = '0;
        drop     = '0;
        for (int i = 0; i < NP; i++) begin
            d         = int'(head[i][DataWidth-1 -: AddrWidth]);
            is_local  = (d >= LocalBase) && (d < LocalBase + NUM_PE);
            dest[i]   = is_local ? PW'(d - LocalBase) : PW'(NUM_PE);
            // A non-local address from a PE goes up the tree.
            // A non-local address from the uplink is a misroute and is discarded.
            routed[i] = not_empty[i] && (is_local || (i < NUM_PE));
            drop[i]   = not_empty[i] && !is_local && (i == NUM_PE);
        end
    end

    // ---------------------------------------------------- per-output arbiter
    // An output grants only when its stage can take a flit this cycle.
    // This keeps rr_ptr unchanged while the stage is stalled.
    logic [NP-1:0][PW-1:0] rr_ptr_q, gnt_idx;
    logic [NP-1:0]         gnt_any;
    logic [NP-1:0][NP-1:0] gnt;      // [output][input]

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_any = '0;
        gnt_idx = '0;
        for (int o = 0; o < NP; o++) begin
            if (!out_valid_q[o] || out_ready[o]) begin
                for (int k = 0; k < NP; k++) begin
                    idx = int'(rr_ptr_q[o]) + k;
                    if (idx >= NP) idx = idx - NP;
                    if (!gnt_any[o] && routed[idx] && (dest[idx] == PW'(o))) begin
                        gnt_any[o]     = 1'b1;
                        gnt_idx[o]     = PW'(idx);
                        gnt[o][idx]    = 1'b1;
                    end
                end
            end
        end
    end

    // Each head decodes to a single output, so at most one grant bit is set per input.
    always_comb begin
        pop = drop;
        for (int o = 0; o < NP; o++) pop = pop | gnt[o];
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NP; i++)
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data[i];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + FAW'(1);
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + FAW'(1);
                cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
            end
            for (int o = 0; o < NP; o++) begin
                if (gnt_any[o]) begin
                    out_valid_q[o] <= 1'b1;
                    out_data_q[o]  <= head[gnt_idx[o]];
                    rr_ptr_q[o]    <= (gnt_idx[o] == PW'(NUM_PE)) ? '0 : gnt_idx[o] + PW'(1);
                end else if (out_ready[o]) begin
                    out_valid_q[o] <= 1'b0;
                end
            end
            if (drop[NUM_PE] && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_hnoc_leaf_router.sv
// tb_hnoc_leaf_router
//   Drives the hnoc_leaf_router ports with random and directed traffic.
//   Each flit is checked against a reference model of the routing rules.
//   A monitor process does the checking. It logs every flit the router
//   accepts into a per-(source, output) queue. When a flit leaves an output,
//   the monitor requires it to be the oldest pending flit of one source for
//   that output.
module tb_hnoc_leaf_router;
    localparam int DW  = 36;
    localparam int AW  = 4;
    localparam int NPE = 4;
    localparam int LB  = 0;
    localparam int FD  = 4;
    localparam int NP  = NPE + 1;

    logic i_clk   = 1'b0;
    logic i_reset = 1'b1;

    logic [NP-1:0][DW-1:0] drv_d = '0;
    logic [NP-1:0]         drv_v = '0;
    logic [NP-1:0]         drv_r = '0;

    logic [NPE*DW-1:0] pe_din, pe_dout;
    logic [DW-1:0]     up_din, up_dout;
    logic [NPE-1:0]    pe_v, pe_rdy_o, pe_vo, pe_rdy_i;
    logic              up_v, up_rdy_o, up_vo, up_rdy_i;
    logic [7:0]        drop_cnt;

    logic [NP-1:0]         in_rdy, out_v;
    logic [NP-1:0][DW-1:0] out_d;

    assign {up_din, pe_din}     = drv_d;
    assign {up_v, pe_v}         = drv_v;
    assign {up_rdy_i, pe_rdy_i} = drv_r;
    assign in_rdy = {up_rdy_o, pe_rdy_o};
    assign out_v  = {up_vo, pe_vo};
    assign out_d  = {up_dout, pe_dout};

    hnoc_leaf_router #(
        .DataWidth(DW), .AddrWidth(AW), .NUM_PE(NPE), .LocalBase(LB), .FifoDepth(FD)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_pe_data       (pe_din),
        .i_pe_data_valid (pe_v),
        .o_pe_data_ready (pe_rdy_o),
        .o_pe_data       (pe_dout),
        .o_pe_data_valid (pe_vo),
        .i_pe_data_ready (pe_rdy_i),
        .i_up_data       (up_din),
        .i_up_data_valid (up_v),
        .o_up_data_ready (up_rdy_o),
        .o_up_data       (up_dout),
        .o_up_data_valid (up_vo),
        .i_up_data_ready (up_rdy_i),
        .o_drop_count    (drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    // ------------------------------------------------------ reference model
    logic [DW-1:0] expq [NP*NP][$];   // index src*NP + output
    int            olog [NP][$];      // source order seen at each output
    int            drop_m   = 0;
    int            checks   = 0;
    int            failures = 0;
    int            seq      = 0;
    logic [NP-1:0]         hold_v = '0;
    logic [NP-1:0][DW-1:0] hold_d = '0;

    // Output index for a flit, or -1 when the flit must be discarded.
    function automatic int route(input int src, input logic [DW-1:0] d);
        int dst = int'(d[DW-1 -: AW]);
        if (dst >= LB && dst < LB + NPE) return dst - LB;
        if (src < NPE) return NPE;
        return -1;
    endfunction

    function automatic logic [DW-1:0] mkflit(input int src, input int dst);
        seq++;
        return {4'(dst), 4'(src), 28'(seq)};
    endfunction

    function automatic int pending();
        int n = 0;
        for (int k = 0; k < NP*NP; k++) n += expq[k].size();
        return n;
    endfunction

    // Monitor: inputs are stable from posedge+1 to the next posedge.
    // A valid && ready seen here therefore completes at the coming edge.
    initial forever begin
        int r;
        bit found;
        @(negedge i_clk);
        if (i_reset) begin
            foreach (expq[k]) expq[k].delete();
            drop_m = 0;
            hold_v = '0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (drv_v[p] && in_rdy[p]) begin
                    r = route(p, drv_d[p]);
                    if (r < 0) begin
                        if (drop_m < 255) drop_m++;
                    end else begin
                        expq[p*NP + r].push_back(drv_d[p]);
                    end
                end
            end
            for (int o = 0; o < NP; o++) begin
                if (hold_v[o]) begin
                    checks++;
                    if (!out_v[o] || out_d[o] !== hold_d[o]) begin
                        failures++;
                        $display("FAIL egress_hold out=%0d actual v=%0b d=%h required v=1 d=%h",
                                 o, out_v[o], out_d[o], hold_d[o]);
                    end
                end
                hold_v[o] = out_v[o] && !drv_r[o];
                hold_d[o] = out_d[o];
                if (out_v[o] && drv_r[o]) begin
                    found = 1'b0;
                    for (int s = 0; s < NP && !found; s++) begin
                        if (expq[s*NP + o].size() > 0 && expq[s*NP + o][0] === out_d[o]) begin
                            found = 1'b1;
                            void'(expq[s*NP + o].pop_front());
                            olog[o].push_back(s);
                        end
                    end
                    checks++;
                    if (!found) begin
                        failures++;
                        $display("FAIL egress_data out=%0d actual=%h required=oldest pending flit for this output",
                                 o, out_d[o]);
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------- tasks
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Keep every asserted valid stable until its handshake completes.
    task automatic hold(input int budget);
        logic [NP-1:0] f;
        int n;
        n = 0;
        while (drv_v != '0 && n < budget) begin
            @(negedge i_clk);
            f = drv_v & in_rdy;
            @(posedge i_clk);
            #1;
            drv_v = drv_v & ~f;
            n++;
        end
        chk("ingress_accept_timeout", 64'(drv_v), 64'(0));
        drv_v = '0;
    endtask

    task automatic drain();
        drv_r = {NP{1'b1}};
        hold(200);
        repeat (30) tick();
        chk("scoreboard_pending", 64'(pending()), 64'(0));
    endtask

    // Random valid/data/ready traffic. If rst_at >= 0, the task asserts
    // reset between edges in that cycle and returns.
    task automatic random_phase(input int cycles, input int rst_at);
        logic [NP-1:0] f;
        int dst;
        for (int c = 0; c < cycles; c++) begin
            @(negedge i_clk);
            f = drv_v & in_rdy;
            @(posedge i_clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (!drv_v[p] || f[p]) begin
                    if ($urandom_range(0, 99) < 50) dst = LB + int'($urandom_range(0, NPE-1));
                    else                             dst = int'($urandom_range(0, 15));
                    drv_v[p] = ($urandom_range(0, 99) < 60);
                    drv_d[p] = mkflit(p, dst);
                end
            end
            for (int o = 0; o < NP; o++) drv_r[o] = ($urandom_range(0, 99) < 70);
            if (c == rst_at) begin
                #2;
                i_reset = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    // ----------------------------------------------------------------- main
    initial begin
        int base, acc, stalls, exp_order[4];
        bit fired, ok;
        logic [DW-1:0] fl;
        exp_order[0] = 0; exp_order[1] = 2; exp_order[2] = 3; exp_order[3] = NPE;

        // reset state
        repeat (3) @(negedge i_clk);
        chk("reset_ready", 64'(in_rdy), 64'(0));
        chk("reset_valid", 64'(out_v), 64'(0));
        chk("reset_data_nonzero", 64'(out_d != '0), 64'(0));
        chk("reset_drop", 64'(drop_cnt), 64'(0));
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        #1;
        chk("release_ready", 64'(in_rdy), 64'({NP{1'b1}}));

        // loopback PE1 -> PE1, two-cycle latency
        drv_r    = {NP{1'b1}};
        drv_d[1] = 36'h1_2345_6789;
        drv_v[1] = 1'b1;
        tick();
        drv_v = '0;
        chk("loopback_t1_valid", 64'(out_v), 64'(0));
        tick();
        chk("loopback_valid", 64'(out_v), 64'(5'b00010));
        chk("loopback_data", 64'(out_d[1]), 64'(36'h1_2345_6789));
        chk("loopback_drop", 64'(drop_cnt), 64'(0));
        tick();
        chk("loopback_cleared", 64'(out_v), 64'(0));

        // contention on output 2 from PE0, PE2, PE3 and the uplink
        base = olog[2].size();
        for (int b = 0; b < 2; b++) begin
            drv_d[0] = mkflit(0, 2);
            drv_d[2] = mkflit(2, 2);
            drv_d[3] = mkflit(3, 2);
            drv_d[4] = mkflit(4, 2);
            drv_v    = 5'b11101;
            hold(10);
            repeat (8) tick();
        end
        chk("contention_count", 64'(olog[2].size() - base), 64'(8));
        for (int k = 0; k < 8; k++)
            if (olog[2].size() > base + k)
                chk($sformatf("contention_order_%0d", k), 64'(olog[2][base + k]), 64'(exp_order[k % 4]));

        // backpressure: uplink egress stalled while PE0 streams uplink traffic
        drv_r    = 5'b01111;
        acc      = 0;
        drv_d[0] = mkflit(0, 9);
        drv_v[0] = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge i_clk);
            fired = drv_v[0] && in_rdy[0];
            if (fired) acc++;
            @(posedge i_clk);
            #1;
            if (fired) drv_d[0] = mkflit(0, 9);
        end
        chk("bp_accepted", 64'(acc), 64'(FD + 1));
        chk("bp_ready_low", 64'(in_rdy[0]), 64'(0));
        drain();

        // random traffic against the scoreboard
        random_phase(800, -1);
        drain();
        chk("random_drop_count", 64'(drop_cnt), 64'(drop_m));

        // misroutes from the uplink mixed with dst=3 flits
        base   = olog[3].size();
        stalls = 0;
        drv_r  = {NP{1'b1}};
        for (int i = 0; i < 300; i++) begin
            drv_d[4] = mkflit(4, (i % 10 == 0) ? 3 : 9);
            drv_v[4] = 1'b1;
            do begin
                @(negedge i_clk);
                ok = in_rdy[4];
                if (!ok) stalls++;
                @(posedge i_clk);
                #1;
            end while (!ok && stalls < 50);
        end
        drv_v = '0;
        repeat (10) tick();
        chk("misroute_stalls", 64'(stalls), 64'(0));
        chk("misroute_drop_sat", 64'(drop_cnt), 64'(255));
        chk("misroute_drop_model", 64'(drop_cnt), 64'(drop_m));
        chk("misroute_pe3_count", 64'(olog[3].size() - base), 64'(30));
        chk("misroute_pending", 64'(pending()), 64'(0));

        // asynchronous reset in the middle of random traffic
        random_phase(30, 20);
        #1;
        chk("arst_valid", 64'(out_v), 64'(0));
        chk("arst_data_nonzero", 64'(out_d != '0), 64'(0));
        chk("arst_ready", 64'(in_rdy), 64'(0));
        chk("arst_drop", 64'(drop_cnt), 64'(0));
        drv_v = '0;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;
        #1;
        chk("arst_release_ready", 64'(in_rdy), 64'({NP{1'b1}}));
        chk("arst_release_valid", 64'(out_v), 64'(0));
        drv_r    = {NP{1'b1}};
        fl       = mkflit(2, 0);
        drv_d[2] = fl;
        drv_v[2] = 1'b1;
        tick();
        drv_v = '0;
        chk("arst_lat_t1", 64'(out_v), 64'(0));
        tick();
        chk("arst_lat_valid", 64'(out_v), 64'(5'b00001));
        chk("arst_lat_data", 64'(out_d[0]), 64'(fl));
        repeat (5) tick();
        chk("arst_pending", 64'(pending()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
